// File: rtl/pingpong_framebuf_pkg.sv
// rtl/pingpong_framebuf_pkg.sv - shared FSM state type and default grid geometry
package pingpong_framebuf_pkg;

   typedef enum logic [1:0] {
      WRITE   = 2'd0,
      PENDING = 2'd1,
      CLEAR   = 2'd2
   } fb_state_t;

   localparam int DEF_GRID_W = 32;
   localparam int DEF_GRID_H = 24;
   localparam int DEF_BLOCK  = 20;
   localparam int DEF_PIX_W  = 8;

endpackage

// File: rtl/framebuf_ram.sv
// rtl/framebuf_ram.sv - single-write, registered-read pixel buffer
module framebuf_ram #(
   parameter int DEPTH  = 768,
   parameter int ADDR_W = 10,
   parameter int PIX_W  = 8
)(
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [PIX_W-1:0]  i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [PIX_W-1:0]  o_rdata
);

   logic [PIX_W-1:0] r_mem [DEPTH];
   logic [PIX_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/pingpong_framebuf.sv
// rtl/pingpong_framebuf.sv - double-buffered block-scaled VGA frame buffer
// Define PINGPONG_FRAMEBUF_CLEAR_EN to zero the new back buffer after every swap.
module pingpong_framebuf
   import pingpong_framebuf_pkg::*;
#(
   parameter int GRID_W = DEF_GRID_W,
   parameter int GRID_H = DEF_GRID_H,
   parameter int BLOCK  = DEF_BLOCK,
   parameter int PIX_W  = DEF_PIX_W,
   parameter int ADDR_W = $clog2(GRID_W*GRID_H)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic [9:0]        vga_hc,
   input  logic [9:0]        vga_vc,
   output logic [PIX_W-1:0]  pix_out,
   output logic              pix_out_valid,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   input  logic              wr_commit,
   output logic              swap_pending,
   output logic              front_sel
);

   localparam int NPIX = GRID_W * GRID_H;

   fb_state_t         r_state;
   logic              r_front_sel;
   logic              r_wr_ready;
   logic              r_swap_pending;
   logic              r_out_valid;
   logic              r_rd_sel;

   logic [31:0]       w_hc;
   logic [31:0]       w_vc;
   logic              w_in_grid;
   logic [ADDR_W-1:0] w_rd_addr;
   logic              w_wr_fire;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [PIX_W-1:0]  w_wdata;
   logic [PIX_W-1:0]  w_rd0;
   logic [PIX_W-1:0]  w_rd1;

   assign w_hc      = 32'(vga_hc);
   assign w_vc      = 32'(vga_vc);
   assign w_in_grid = (w_hc < 32'(GRID_W * BLOCK)) && (w_vc < 32'(GRID_H * BLOCK));
   // Off-grid reads are parked at address 0; pix_out is masked by r_out_valid anyway.
   assign w_rd_addr = w_in_grid ? ADDR_W'((w_vc / BLOCK) * GRID_W + w_hc / BLOCK) : '0;

   assign w_wr_fire = !rst && wr_valid && r_wr_ready && (32'(wr_addr) < 32'(NPIX));

`ifdef PINGPONG_FRAMEBUF_CLEAR_EN
   logic [ADDR_W-1:0] r_clr_cnt;
   logic              r_commit_latched;
   logic              w_clearing;

   assign w_clearing = !rst && (r_state == CLEAR);
   assign w_we       = w_wr_fire || w_clearing;
   assign w_waddr    = w_clearing ? r_clr_cnt : wr_addr;
   assign w_wdata    = w_clearing ? '0 : wr_data;
`else
   assign w_we       = w_wr_fire;
   assign w_waddr    = wr_addr;
   assign w_wdata    = wr_data;
`endif

   // Writes always land in the buffer that is not being displayed.
   framebuf_ram #(.DEPTH(NPIX), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) u_ram0 (
      .clk     (clk),
      .i_we    (w_we && r_front_sel),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rd0)
   );

   framebuf_ram #(.DEPTH(NPIX), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) u_ram1 (
      .clk     (clk),
      .i_we    (w_we && !r_front_sel),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rd1)
   );

   always_ff @(posedge clk) begin
      r_rd_sel <= r_front_sel;
      if (rst)
         r_out_valid <= 1'b0;
      else
         r_out_valid <= w_in_grid;
   end

   assign pix_out       = r_out_valid ? (r_rd_sel ? w_rd1 : w_rd0) : '0;
   assign pix_out_valid = r_out_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= WRITE;
         r_front_sel    <= 1'b0;
         r_wr_ready     <= 1'b1;
         r_swap_pending <= 1'b0;
`ifdef PINGPONG_FRAMEBUF_CLEAR_EN
         r_clr_cnt        <= '0;
         r_commit_latched <= 1'b0;
`endif
      end else begin
         case (r_state)
            WRITE: begin
               if (wr_commit) begin
                  r_state        <= PENDING;
                  r_wr_ready     <= 1'b0;
                  r_swap_pending <= 1'b1;
               end
            end
            PENDING: begin
               if (frame_start) begin
                  r_front_sel    <= ~r_front_sel;
                  r_swap_pending <= 1'b0;
`ifdef PINGPONG_FRAMEBUF_CLEAR_EN
                  r_state        <= CLEAR;
                  r_clr_cnt      <= '0;
`else
                  r_state        <= WRITE;
                  r_wr_ready     <= 1'b1;
`endif
               end
            end
`ifdef PINGPONG_FRAMEBUF_CLEAR_EN
            CLEAR: begin
               r_clr_cnt <= r_clr_cnt + 1'b1;
               if (wr_commit)
                  r_commit_latched <= 1'b1;
               if (r_clr_cnt == ADDR_W'(NPIX - 1)) begin
                  r_commit_latched <= 1'b0;
                  if (r_commit_latched || wr_commit) begin
                     r_state        <= PENDING;
                     r_swap_pending <= 1'b1;
                  end else begin
                     r_state        <= WRITE;
                     r_wr_ready     <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               r_state        <= WRITE;
               r_wr_ready     <= 1'b1;
               r_swap_pending <= 1'b0;
            end
         endcase
      end
   end

   assign wr_ready     = r_wr_ready;
   assign swap_pending = r_swap_pending;
   assign front_sel    = r_front_sel;

endmodule
